// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// bus geometry and the alignment rule used to reject bad requests.
package load_store_unit_pkg;

    localparam int BUS_W = 32;
    localparam int BE_W  = BUS_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    // Size 11 has no encoding, so it is treated the same as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = |addr_lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed req/ack data bus with byte enables between the LSU and memory.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic              busReq;
    logic              busWe;
    logic [BUS_W-1:0]  busAddr;
    logic [BUS_W-1:0]  busWdata;
    logic [BE_W-1:0]   busByteEn;
    logic              busAck;
    logic [BUS_W-1:0]  busRdata;

    modport master (
        output busReq, busWe, busAddr, busWdata, busByteEn,
        input  busAck, busRdata
    );

    modport slave (
        input  busReq, busWe, busAddr, busWdata, busByteEn,
        output busAck, busRdata
    );

endinterface

// File: rtl/load_store_unit_load_align_ext.sv
// Moves the addressed byte/halfword of a bus read word down to bit 0 and
// sign- or zero-extends it to 32 bits.
module load_align_ext
    import load_store_unit_pkg::*;
(
    input  logic [BUS_W-1:0] rdata,
    input  logic [1:0]       addr_lo,
    input  logic [1:0]       size,
    input  logic             uns,
    output logic [BUS_W-1:0] result
);

    logic [BUS_W-1:0] shifted_s;

    // Lane select followed by extension according to the access size.
    always_comb begin
        shifted_s = rdata >> {addr_lo, 3'b000};
        case (size)
            SZ_B:    result = {{24{~uns & shifted_s[7]}}, shifted_s[7:0]};
            SZ_H:    result = {{16{~uns & shifted_s[15]}}, shifted_s[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a decoded memory request into one req/ack bus access,
// stalls the core meanwhile and returns the extended load data.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_memReq,
    input  logic              i_memWrite,
    input  logic [2:0]        i_funct3,
    input  logic [BUS_W-1:0]  i_addr,
    input  logic [BUS_W-1:0]  i_wdata,
    output logic              o_stall,
    output logic              o_valid,
    output logic [BUS_W-1:0]  o_rdata,
    output logic              o_misaligned,
    output logic              o_busErr,
    load_store_unit_if.master bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic mis_s, accept_s, timeout_hit_s;
    logic [BE_W-1:0]  be_s;
    logic [BUS_W-1:0] lane_s, ext_s;

    logic req_r, we_r, valid_r, err_r, uns_r;
    logic req_next_s, we_next_s, valid_next_s, err_next_s, uns_next_s;
    logic [BUS_W-1:0] addr_r, wdata_r, rdata_r, addr_next_s, wdata_next_s, rdata_next_s;
    logic [BE_W-1:0]  be_r, be_next_s;
    logic [1:0]       addr_lo_r, size_r, addr_lo_next_s, size_next_s;

    assign mis_s         = is_misaligned(i_funct3[1:0], i_addr[1:0]);
    assign accept_s      = (state_r == ST_IDLE) && i_memReq && !mis_s;
    assign timeout_hit_s = (TIMEOUT != 0) && (cnt_r == CNT_LAST);

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        case (i_funct3[1:0])
            SZ_B: begin
                be_s   = 4'b0001 << i_addr[1:0];
                lane_s = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                be_s   = 4'b0011 << {i_addr[1], 1'b0};
                lane_s = {2{i_wdata[15:0]}};
            end
            default: begin
                be_s   = 4'b1111;
                lane_s = i_wdata;
            end
        endcase
    end

    load_align_ext u_align (
        .rdata   (bus.busRdata),
        .addr_lo (addr_lo_r),
        .size    (size_r),
        .uns     (uns_r),
        .result  (ext_s)
    );

    // FSM next state; ack wins over timeout when both land on the same cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_BUSY;
                else          state_next_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (bus.busAck || timeout_hit_s) state_next_s = ST_DONE;
                else                             state_next_s = ST_BUSY;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: combinational stall/misaligned, next values of registered outputs.
    always_comb begin
        o_stall        = accept_s || (state_r == ST_BUSY);
        o_misaligned   = (state_r == ST_IDLE) && i_memReq && mis_s;
        req_next_s     = (state_next_s == ST_BUSY);
        valid_next_s   = (state_next_s == ST_DONE);
        err_next_s     = (state_r == ST_BUSY) && !bus.busAck && timeout_hit_s;
        rdata_next_s   = rdata_r;
        cnt_next_s     = {CNT_W{1'b0}};
        addr_next_s    = addr_r;
        wdata_next_s   = wdata_r;
        be_next_s      = be_r;
        we_next_s      = we_r;
        addr_lo_next_s = addr_lo_r;
        size_next_s    = size_r;
        uns_next_s     = uns_r;
        if (state_r == ST_BUSY && !bus.busAck) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = {CNT_W{1'b0}};
        end
        if (state_r == ST_BUSY && bus.busAck && !we_r) begin
            rdata_next_s = ext_s;
        end else begin
            rdata_next_s = rdata_r;
        end
        if (accept_s) begin
            addr_next_s    = {i_addr[31:2], 2'b00};
            wdata_next_s   = lane_s;
            be_next_s      = be_s;
            we_next_s      = i_memWrite;
            addr_lo_next_s = i_addr[1:0];
            size_next_s    = i_funct3[1:0];
            uns_next_s     = i_funct3[2];
        end else begin
            addr_next_s    = addr_r;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            uns_r     <= 1'b0;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            rdata_r   <= 32'h0000_0000;
            be_r      <= 4'b0000;
            addr_lo_r <= 2'b00;
            size_r    <= 2'b00;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            req_r     <= req_next_s;
            we_r      <= we_next_s;
            valid_r   <= valid_next_s;
            err_r     <= err_next_s;
            uns_r     <= uns_next_s;
            addr_r    <= addr_next_s;
            wdata_r   <= wdata_next_s;
            rdata_r   <= rdata_next_s;
            be_r      <= be_next_s;
            addr_lo_r <= addr_lo_next_s;
            size_r    <= size_next_s;
        end
    end

    assign bus.busReq    = req_r;
    assign bus.busWe     = we_r;
    assign bus.busAddr   = addr_r;
    assign bus.busWdata  = wdata_r;
    assign bus.busByteEn = be_r;
    assign o_valid       = valid_r;
    assign o_busErr      = err_r;
    assign o_rdata       = rdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed plus random accesses against a
// byte-level reference model, with a randomly delaying memory responder.
module tb_load_store_unit;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        we;
        logic        err;
        int          reqc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall, valid, misaligned, bus_err;
    logic [31:0] rdata;

    int          n_vec = 0;
    int          n_fail = 0;
    int          ack_delay = 0;
    logic [31:0] mem_word = 32'h0;
    logic [31:0] last_rdata = 32'h0;
    exp_t        q[$];

    load_store_unit_if bus_if();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_memReq     (mem_req),
        .i_memWrite   (mem_write),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall),
        .o_valid      (valid),
        .o_rdata      (rdata),
        .o_misaligned (misaligned),
        .o_busErr     (bus_err),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_mis(input bit [2:0] f3, input bit [31:0] a);
        int sz = int'(f3[1:0]);
        return (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    endfunction

    // Reference: byte-level arithmetic on the access, independent of lane muxes.
    function automatic exp_t model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                                   input bit [31:0] wd, input bit [31:0] word, input int delay);
        exp_t e;
        int nb = 1 << int'(f3[1:0]);
        int off = int'(a[1:0]);
        longint v;
        e.addr = {a[31:2], 2'b00};
        e.be = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
        e.we = we;
        e.err = (delay >= TO);
        e.reqc = e.err ? TO : delay + 1;
        v = {32'd0, word} >> (8 * off);
        if (nb < 4) begin
            v = v & ((64'd1 << (8 * nb)) - 64'd1);
            if (!f3[2] && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
        end
        e.rdata = (!we && !e.err) ? v[31:0] : last_rdata;
        return e;
    endfunction

    // Memory responder: acks after ack_delay BUSY cycles, stray acks when idle.
    initial begin
        int cnt = 0;
        bus_if.busAck = 1'b0;
        bus_if.busRdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_if.busReq) begin
                bus_if.busAck = (cnt == ack_delay);
                bus_if.busRdata = (cnt == ack_delay) ? mem_word : $urandom;
                cnt++;
            end else begin
                bus_if.busAck = 1'($urandom_range(0, 1));
                bus_if.busRdata = $urandom;
                cnt = 0;
            end
        end
    end

    // Monitor: bus fields on the first BUSY cycle, result on every o_valid.
    initial begin
        bit prev_req = 1'b0;
        int reqc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                reqc = 0;
            end else begin
                if (bus_if.busReq) begin
                    if (!prev_req) begin
                        if (q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
                        else begin
                            check("bus_addr", bus_if.busAddr, q[0].addr);
                            check("bus_be", {28'd0, bus_if.busByteEn}, {28'd0, q[0].be});
                            check("bus_we", {31'd0, bus_if.busWe}, {31'd0, q[0].we});
                            if (q[0].we) check("bus_wdata", bus_if.busWdata, q[0].wdata);
                        end
                    end
                    check("stall_busy", {31'd0, stall}, 32'd1);
                    reqc++;
                end
                if (valid) begin
                    if (q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        check("rdata", rdata, e.rdata);
                        check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                        check("req_cycles", reqc, e.reqc);
                        check("done_after_busy", {31'd0, prev_req}, 32'd1);
                        check("stall_done", {31'd0, stall}, 32'd0);
                        check("req_done", {31'd0, bus_if.busReq}, 32'd0);
                    end
                    reqc = 0;
                end else if (bus_err) begin
                    check("err_without_valid", {31'd0, bus_err}, 32'd0);
                end
                prev_req = bus_if.busReq;
            end
        end
    end

    task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit [31:0] word, input int delay);
        exp_t e;
        bit mis = model_mis(f3, a);
        ack_delay = delay;
        mem_word = word;
        mem_req = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata = wd;
        #1;
        check("misaligned", {31'd0, misaligned}, {31'd0, mis});
        check("stall_accept", {31'd0, stall}, {31'd0, !mis});
        if (!mis) begin
            e = model(we, f3, a, wd, word, delay);
            last_rdata = e.rdata;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        mem_req = 1'b0;
        if (mis) begin
            for (int k = 0; k < 2; k++) begin
                check("mis_no_req", {31'd0, bus_if.busReq}, 32'd0);
                check("mis_no_valid", {31'd0, valid}, 32'd0);
                @(negedge clk);
            end
        end else begin
            for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
            if (q.size() != 0) begin
                check("completion_timeout", q.size(), 32'd0);
                q.delete();
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        #2;
        check("reset_req", {31'd0, bus_if.busReq}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEADBEEF, 0);
        issue(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 3);
        issue(1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 3);
        issue(1'b1, 3'b001, 32'h0000_2002, 32'h1234ABCD, 32'h0, 1);
        issue(1'b0, 3'b001, 32'h0000_2001, 32'h0, 32'h0, 0);
        issue(1'b0, 3'b010, 32'h0000_2002, 32'h0, 32'h0, 0);
        issue(1'b0, 3'b011, 32'h0000_2000, 32'h0, 32'h0, 0);
        issue(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hCAFEF00D, 9);
        issue(1'b0, 3'b001, 32'h0000_3002, 32'h0, 32'h8001_7FFF, 3);
        issue(1'b0, 3'b101, 32'h0000_3002, 32'h0, 32'h8001_7FFF, 2);

        for (int n = 0; n < 60; n++) begin
            issue(1'($urandom_range(0, 2) == 0), 3'($urandom), $urandom, $urandom, $urandom,
                  $urandom_range(0, 5));
        end

        // Asynchronous reset in the middle of an access.
        ack_delay = 20;
        mem_word = 32'h1111_2222;
        mem_req = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_4000;
        e = model(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h1111_2222, 20);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        mem_req = 1'b0;
        check("req_before_reset", {31'd0, bus_if.busReq}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("req_async_drop", {31'd0, bus_if.busReq}, 32'd0);
        check("stall_in_reset", {31'd0, stall}, 32'd0);
        q.delete();
        last_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_addr", bus_if.busAddr, 32'd0);
        check("post_reset_be", {28'd0, bus_if.busByteEn}, 32'd0);
        check("post_reset_wdata", bus_if.busWdata, 32'd0);
        check("post_reset_we", {31'd0, bus_if.busWe}, 32'd0);
        check("post_reset_valid", {31'd0, valid}, 32'd0);
        check("post_reset_rdata", rdata, 32'd0);
        issue(1'b0, 3'b000, 32'h0000_5001, 32'h0, 32'h0000_7F00, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
